// File: rtl/mem_arbiter_if.sv
// Bus bundle between mem_arbiter, its two cache clients and main memory.
// master = arbiter side, slave = clients/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [DATA_W-1:0] d_writedata;
    logic [DATA_W-1:0] d_readdata;
    logic              d_busywait;

    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [DATA_W-1:0] i_readdata;
    logic              i_busywait;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;
    logic              mem_busywait;

    logic              err_timeout;

    // Handshake: a client holds its request until it samples its busywait low;
    // readdata is valid in that same cycle and stays put until its next read.
    modport master (
        input  d_read, d_write, d_address, d_writedata,
        output d_readdata, d_busywait,
        input  i_read, i_address,
        output i_readdata, i_busywait,
        output mem_read, mem_write, mem_address, mem_writedata,
        input  mem_readdata, mem_busywait,
        output err_timeout
    );

    modport slave (
        output d_read, d_write, d_address, d_writedata,
        input  d_readdata, d_busywait,
        output i_read, i_address,
        input  i_readdata, i_busywait,
        input  mem_read, mem_write, mem_address, mem_writedata,
        output mem_readdata, mem_busywait,
        input  err_timeout
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between dcache and icache.
// All state moves on the falling clock edge, like the cache controllers it serves.
module mem_arbiter #(
    parameter int ADDR_W  = 28,
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 255
) (
    input  logic          CLK,
    input  logic          RESET,
    mem_arbiter_if.master bus,
    output logic [2:0]    o_state
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GRANT_D   = 3'd1,
        S_GRANT_I   = 3'd2,
        S_RELEASE_D = 3'd3,
        S_RELEASE_I = 3'd4
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_last_i;
    logic              r_is_write;
    logic [7:0]        r_cnt;
    logic              r_err;
    logic [DATA_W-1:0] r_d_rdata;
    logic [DATA_W-1:0] r_i_rdata;

    logic              w_d_req;
    logic              w_i_req;
    logic              w_done;
    logic              w_tmo;
    logic              w_mem_read;
    logic              w_mem_write;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_d_busy;
    logic              w_i_busy;

    assign w_d_req = bus.d_read | bus.d_write;
    assign w_i_req = bus.i_read;
    assign w_done  = ~bus.mem_busywait;
    assign w_tmo   = (r_cnt == TMO_LAST);

    always_comb begin
        w_next      = r_state;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_d_busy    = w_d_req;
        w_i_busy    = w_i_req;
        case (r_state)
            S_IDLE: begin
                // On a tie the client that did not win last time goes first.
                if (w_d_req && (!w_i_req || r_last_i))
                    w_next = S_GRANT_D;
                else if (w_i_req)
                    w_next = S_GRANT_I;
            end
            S_GRANT_D: begin
                w_mem_read  = ~r_is_write;
                w_mem_write = r_is_write;
                w_mem_addr  = bus.d_address;
                w_mem_wdata = bus.d_writedata;
                w_d_busy    = 1'b1;
                if (w_done || w_tmo)
                    w_next = S_RELEASE_D;
            end
            S_GRANT_I: begin
                w_mem_read = 1'b1;
                w_mem_addr = bus.i_address;
                w_i_busy   = 1'b1;
                if (w_done || w_tmo)
                    w_next = S_RELEASE_I;
            end
            S_RELEASE_D: begin
                w_d_busy = 1'b0;
                w_next   = S_IDLE;
            end
            S_RELEASE_I: begin
                w_i_busy = 1'b0;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(negedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_last_i   <= 1'b1;
            r_is_write <= 1'b0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_d_rdata  <= '0;
            r_i_rdata  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    // The operation is latched so a request dropped mid-grant still finishes.
                    r_cnt      <= '0;
                    r_is_write <= bus.d_write;
                end
                S_GRANT_D, S_GRANT_I: begin
                    if (w_done) begin
                        if (r_state == S_GRANT_D && !r_is_write)
                            r_d_rdata <= bus.mem_readdata;
                        if (r_state == S_GRANT_I)
                            r_i_rdata <= bus.mem_readdata;
                        r_last_i <= (r_state == S_GRANT_I);
                    end else if (w_tmo) begin
                        r_err    <= 1'b1;
                        r_last_i <= (r_state == S_GRANT_I);
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_read      = w_mem_read;
    assign bus.mem_write     = w_mem_write;
    assign bus.mem_address   = w_mem_addr;
    assign bus.mem_writedata = w_mem_wdata;
    assign bus.d_busywait    = w_d_busy;
    assign bus.i_busywait    = w_i_busy;
    assign bus.d_readdata    = r_d_rdata;
    assign bus.i_readdata    = r_i_rdata;
    assign bus.err_timeout   = r_err;
    assign o_state           = r_state;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: two client drivers, a behavioural memory
// with random latency, and a reference data model per client address region.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int ADDR_W  = 28;
    localparam int DATA_W  = 128;
    localparam int TIMEOUT = 255;
    localparam int BUDGET  = 400;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [2:0] o_state;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .bus    (bus.master),
        .o_state(o_state)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Memory model: dcache owns addresses with MSB 0, icache reads addresses with MSB 1.
    logic [DATA_W-1:0] mem_arr [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] d_model [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] d_exp_rd = '0;
    int                mem_left = 3;
    int                mem_lat_fix = 0;
    bit                mem_stuck = 1'b0;
    bit                grant_log[$];

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        logic [31:0] w;
        w = 32'(a) ^ 32'h5A5A_0000;
        return {w, ~w, w + 32'd1, w ^ 32'h0000_FFFF};
    endfunction

    function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return pat(a);
    endfunction

    assign bus.mem_busywait = mem_stuck || ((bus.mem_read || bus.mem_write) && mem_left != 0);

    always @(posedge CLK) begin
        if (bus.mem_read || bus.mem_write) begin
            bus.mem_readdata = mem_rd(bus.mem_address);
            if (mem_left > 0) mem_left = mem_left - 1;
            if (mem_left == 0 && !mem_stuck) begin
                if (bus.mem_write) mem_arr[bus.mem_address] = bus.mem_writedata;
                grant_log.push_back(bus.mem_address[ADDR_W-1]);
            end
        end else begin
            mem_left = (mem_lat_fix != 0) ? mem_lat_fix : int'($urandom_range(1, 4));
        end
    end

    // Client driver tasks
    task automatic d_start(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] wd);
        @(posedge CLK);
        bus.d_read = rd; bus.d_write = wr; bus.d_address = a; bus.d_writedata = wd;
    endtask

    task automatic i_start(input logic [ADDR_W-1:0] a);
        @(posedge CLK);
        bus.i_read = 1'b1; bus.i_address = a;
    endtask

    task automatic wait_d(output int n);
        n = 0;
        do begin @(posedge CLK); #1; n++; end while (bus.d_busywait && n < BUDGET);
    endtask

    task automatic wait_i(output int n);
        n = 0;
        do begin @(posedge CLK); #1; n++; end while (bus.i_busywait && n < BUDGET);
    endtask

    task automatic d_txn(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] wd, input bit keep,
                         output int n, output logic [DATA_W-1:0] rdata);
        d_start(rd, wr, a, wd);
        wait_d(n);
        rdata = bus.d_readdata;
        if (!keep) begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
    endtask

    task automatic i_txn(input logic [ADDR_W-1:0] a, input bit keep,
                         output int n, output logic [DATA_W-1:0] rdata);
        i_start(a);
        wait_i(n);
        rdata = bus.i_readdata;
        if (!keep) bus.i_read = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge CLK); #2;
        RESET = 1'b1;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.i_read = 1'b0;
        mem_stuck = 1'b0;
        d_exp_rd = '0;
        @(posedge CLK); #2;
        RESET = 1'b0;
    endtask

    // dcache traffic: random reads, writes and read+write (treated as write)
    task automatic d_client(input int cnt, input bit gaps);
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] wd, rdata, exp;
        bit wr, both;
        int n;
        for (int k = 0; k < cnt; k++) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(posedge CLK);
            a    = ADDR_W'($urandom_range(0, 15));
            wr   = 1'($urandom_range(0, 1));
            both = wr && ($urandom_range(0, 1) == 1);
            wd   = {$urandom, $urandom, $urandom, $urandom};
            d_txn(!wr || both, wr, a, wd, !gaps && k != cnt - 1, n, rdata);
            checks++;
            if (n >= BUDGET) begin errors++; $display("FAIL d_handshake: waited %0d cycles, required < %0d", n, BUDGET); end
            if (wr) begin
                d_model[a] = wd;
                exp = d_exp_rd;
            end else begin
                exp = d_model.exists(a) ? d_model[a] : pat(a);
                d_exp_rd = exp;
            end
            checks++;
            if (rdata !== exp) begin errors++; $display("FAIL d_readdata wr=%0b addr=%h: got %h required %h", wr, a, rdata, exp); end
        end
    endtask

    task automatic i_client(input int cnt, input bit gaps);
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] rdata;
        int n;
        for (int k = 0; k < cnt; k++) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(posedge CLK);
            a = {1'b1, (ADDR_W-1)'($urandom_range(0, 15))};
            i_txn(a, !gaps && k != cnt - 1, n, rdata);
            checks++;
            if (n >= BUDGET) begin errors++; $display("FAIL i_handshake: waited %0d cycles, required < %0d", n, BUDGET); end
            checks++;
            if (rdata !== pat(a)) begin errors++; $display("FAIL i_readdata addr=%h: got %h required %h", a, rdata, pat(a)); end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", o_state); end
        checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_cmd: got %0b%0b required 00", bus.mem_read, bus.mem_write); end
        checks++; if (bus.d_readdata !== '0 || bus.i_readdata !== '0) begin errors++; $display("FAIL reset_readdata: got %h / %h required 0", bus.d_readdata, bus.i_readdata); end
        checks++; if (bus.err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b required 0", bus.err_timeout); end
        checks++; if (bus.d_busywait !== 1'b0 || bus.i_busywait !== 1'b0) begin errors++; $display("FAIL reset_busywait: got %0b%0b required 00", bus.d_busywait, bus.i_busywait); end
        @(posedge CLK); #2;
        RESET = 1'b0;
    endtask

    task automatic test_d_read();
        logic [ADDR_W-1:0] a;
        int n;
        a = 28'h000_0120;
        mem_arr[a] = {16{8'hA5}};
        d_model[a] = {16{8'hA5}};
        mem_lat_fix = 3;
        d_start(1'b1, 1'b0, a, '0);
        @(posedge CLK); #1;
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL dread_cmd: got rd=%0b wr=%0b required rd=1 wr=0", bus.mem_read, bus.mem_write); end
        checks++; if (bus.mem_address !== a) begin errors++; $display("FAIL dread_addr: got %h required %h", bus.mem_address, a); end
        checks++; if (bus.d_busywait !== 1'b1) begin errors++; $display("FAIL dread_busy: got %0b required 1", bus.d_busywait); end
        wait_d(n);
        checks++; if (n + 1 != 4) begin errors++; $display("FAIL dread_latency: got %0d required 4", n + 1); end
        checks++; if (bus.d_readdata !== {16{8'hA5}}) begin errors++; $display("FAIL dread_data: got %h required %h", bus.d_readdata, {16{8'hA5}}); end
        checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL dread_release_cmd: got %0b required 0", bus.mem_read); end
        checks++; if (bus.i_readdata !== '0) begin errors++; $display("FAIL dread_i_untouched: got %h required 0", bus.i_readdata); end
        d_exp_rd = {16{8'hA5}};
        bus.d_read = 1'b0;
        @(posedge CLK); #1;
        checks++; if (bus.d_readdata !== d_exp_rd) begin errors++; $display("FAIL dread_hold: got %h required %h", bus.d_readdata, d_exp_rd); end
    endtask

    task automatic test_write();
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] rdata;
        int n;
        a = 28'h000_0040;
        d_start(1'b0, 1'b1, a, 128'h1234);
        @(posedge CLK); #1;
        checks++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin errors++; $display("FAIL dwrite_cmd: got rd=%0b wr=%0b required rd=0 wr=1", bus.mem_read, bus.mem_write); end
        checks++; if (bus.mem_writedata !== 128'h1234) begin errors++; $display("FAIL dwrite_data: got %h required %h", bus.mem_writedata, 128'h1234); end
        wait_d(n);
        checks++; if (bus.d_busywait !== 1'b0 || bus.d_readdata !== d_exp_rd) begin errors++; $display("FAIL dwrite_readdata: got %h required %h", bus.d_readdata, d_exp_rd); end
        bus.d_write = 1'b0;
        d_model[a] = 128'h1234;
        d_txn(1'b1, 1'b0, a, '0, 1'b0, n, rdata);
        d_exp_rd = 128'h1234;
        checks++; if (rdata !== 128'h1234) begin errors++; $display("FAIL dwrite_readback: got %h required %h", rdata, 128'h1234); end
    endtask

    task automatic test_tie();
        logic [DATA_W-1:0] rd_d, rd_i;
        logic [ADDR_W-1:0] da, ia;
        int nd, ni;
        do_reset();
        grant_log.delete();
        mem_lat_fix = 2;
        da = 28'h000_0200;
        ia = 28'h800_0200;
        fork
            d_txn(1'b1, 1'b0, da, '0, 1'b0, nd, rd_d);
            i_txn(ia, 1'b0, ni, rd_i);
        join
        checks++; if (grant_log.size() != 2 || grant_log[0] !== 1'b0) begin errors++; $display("FAIL tie_first_grant: got %0d grants first=%0b required 2 grants first=0 (D)", grant_log.size(), grant_log.size() > 0 ? grant_log[0] : 1'b1); end
        checks++; if (nd != 3 || ni != 7) begin errors++; $display("FAIL tie_timing: got d=%0d i=%0d cycles required d=3 i=7", nd, ni); end
        checks++; if (rd_d !== pat(da) || rd_i !== pat(ia)) begin errors++; $display("FAIL tie_data: got %h / %h required %h / %h", rd_d, rd_i, pat(da), pat(ia)); end
        d_exp_rd = pat(da);
    endtask

    task automatic test_back_to_back();
        do_reset();
        grant_log.delete();
        mem_lat_fix = 0;
        fork
            d_client(4, 1'b0);
            i_client(4, 1'b0);
        join
        checks++; if (grant_log.size() != 8) begin errors++; $display("FAIL b2b_count: got %0d grants required 8", grant_log.size()); end
        for (int k = 0; k < grant_log.size() && k < 8; k++) begin
            checks++;
            if (grant_log[k] !== 1'(k % 2)) begin errors++; $display("FAIL b2b_order[%0d]: got %0b required %0b", k, grant_log[k], 1'(k % 2)); end
        end
    endtask

    task automatic test_random();
        fork
            d_client(10, 1'b1);
            i_client(10, 1'b1);
        join
    endtask

    task automatic test_timeout();
        int n;
        mem_stuck = 1'b1;
        d_start(1'b1, 1'b0, 28'h000_0300, '0);
        @(posedge CLK); #1;
        checks++; if (bus.err_timeout !== 1'b0 || bus.mem_read !== 1'b1) begin errors++; $display("FAIL tmo_early: got err=%0b rd=%0b required err=0 rd=1", bus.err_timeout, bus.mem_read); end
        wait_d(n);
        checks++; if (n + 1 < TIMEOUT || n + 1 > TIMEOUT + 2) begin errors++; $display("FAIL tmo_cycles: got %0d required %0d..%0d", n + 1, TIMEOUT, TIMEOUT + 2); end
        checks++; if (bus.err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %0b required 1", bus.err_timeout); end
        checks++; if (bus.d_readdata !== d_exp_rd || bus.mem_read !== 1'b0) begin errors++; $display("FAIL tmo_release: got data %h rd=%0b required %h rd=0", bus.d_readdata, bus.mem_read, d_exp_rd); end
        bus.d_read = 1'b0;
        mem_stuck = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (bus.err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %0b required 1", bus.err_timeout); end
        do_reset();
        #1;
        checks++; if (bus.err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %0b required 0", bus.err_timeout); end
    endtask

    task automatic test_reset_mid_grant();
        logic [ADDR_W-1:0] ia;
        logic [DATA_W-1:0] rdata;
        int n;
        ia = 28'h800_0005;
        i_txn(ia, 1'b0, n, rdata);
        checks++; if (bus.i_readdata !== pat(ia)) begin errors++; $display("FAIL mid_pre_data: got %h required %h", bus.i_readdata, pat(ia)); end
        mem_stuck = 1'b1;
        i_start(28'h800_0006);
        @(posedge CLK); #1;
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 28'h800_0006) begin errors++; $display("FAIL mid_grant: got rd=%0b addr=%h required rd=1 addr=8000006", bus.mem_read, bus.mem_address); end
        #2;
        RESET = 1'b1;
        #1;
        checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL mid_reset_cmd: got %0b%0b required 00", bus.mem_read, bus.mem_write); end
        checks++; if (bus.i_readdata !== '0 || bus.d_readdata !== '0 || bus.err_timeout !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs: got %h %h %0b required zeros", bus.i_readdata, bus.d_readdata, bus.err_timeout); end
        checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL mid_reset_state: got %0d required 0", o_state); end
        bus.i_read = 1'b0;
        mem_stuck = 1'b0;
        @(posedge CLK); #2;
        RESET = 1'b0;
        @(posedge CLK); #1;
        checks++; if (o_state !== 3'd0 || bus.mem_read !== 1'b0) begin errors++; $display("FAIL mid_release_idle: got state=%0d rd=%0b required 0 0", o_state, bus.mem_read); end
        i_txn(ia, 1'b0, n, rdata);
        checks++; if (rdata !== pat(ia)) begin errors++; $display("FAIL mid_after_data: got %h required %h", rdata, pat(ia)); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_writedata = '0;
        bus.i_read = 1'b0; bus.i_address = '0;
        test_reset();
        test_d_read();
        test_write();
        test_tie();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_mid_grant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
